// File: rtl/key_pulse_gen.sv
// Active-low key line pulse generator: one accepted request gives exactly HOLD_CYCLES low clocks
// followed by at least GAP_CYCLES high clocks. Define KEY_PULSE_PENDING_EN for a one-deep request queue.
module key_pulse_gen #(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES  = 1024,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned DROP_W      = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              trig_in,
    input  logic              abort_in,
    output logic              trig_ready,
    output logic              key_out,
    output logic              busy,
    output logic              done,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_key;
    logic              r_done;
    logic [DROP_W-1:0] r_drop_cnt;

    logic w_pending;
    logic w_accept;
    logic w_drop;
    logic w_gap_end;

    // Abort has priority: a request seen together with abort is neither taken nor counted.
    assign w_accept  = trig_in && trig_ready && !abort_in;
    assign w_drop    = trig_in && !trig_ready && !abort_in;
    assign w_gap_end = (r_state == S_GAP) && (r_cnt == GAP_LAST);

`ifdef KEY_PULSE_PENDING_EN
    logic r_pending;

    // A request taken while busy is parked here until the current gap runs out.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (abort_in || w_gap_end) begin
            r_pending <= 1'b0;
        end else if (w_accept && (r_state != S_IDLE)) begin
            r_pending <= 1'b1;
        end
    end

    assign w_pending  = r_pending;
    assign trig_ready = (r_state == S_IDLE) || !r_pending;
`else
    assign w_pending  = 1'b0;
    assign trig_ready = (r_state == S_IDLE);
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_key      <= 1'b1;
            r_done     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_ASSERT;
                        r_cnt   <= '0;
                        r_key   <= 1'b0;
                    end
                end
                S_ASSERT: begin
                    if (abort_in || (r_cnt == HOLD_LAST)) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        r_key   <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        // A request landing on the last gap cycle starts immediately rather than queueing.
                        if ((w_pending && !abort_in) || w_accept) begin
                            r_state <= S_ASSERT;
                            r_key   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_key   <= 1'b1;
                end
            endcase
        end
    end

    assign key_out  = r_key;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Randomised self-checking bench for key_pulse_gen (HOLD_CYCLES=8, GAP_CYCLES=4) against a
// timestamp-based reference model.
module tb_key_pulse_gen;

    localparam int unsigned HOLD   = 8;
    localparam int unsigned GAP    = 4;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned DROP_W = 8;
`ifdef KEY_PULSE_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic              clk_in   = 1'b0;
    logic              rst_n    = 1'b0;
    logic              trig_in  = 1'b0;
    logic              abort_in = 1'b0;
    logic              trig_ready;
    logic              key_out;
    logic              busy;
    logic              done;
    logic [DROP_W-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pulse schedule kept as edge timestamps.
    int n;
    int m_end_at;
    int m_idle_at;
    bit m_low;
    bit m_pend;
    bit m_done;
    int m_drop;

    key_pulse_gen #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .CNT_W      (CNT_W),
        .DROP_W     (DROP_W)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .trig_in   (trig_in),
        .abort_in  (abort_in),
        .trig_ready(trig_ready),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_end_at  = -1;
        m_idle_at = -1;
        m_low     = 1'b0;
        m_pend    = 1'b0;
        m_done    = 1'b0;
        m_drop    = 0;
    endtask

    task automatic model_start();
        m_low    = 1'b1;
        m_end_at = n + HOLD;
        m_pend   = 1'b0;
    endtask

    task automatic model_edge(input bit trig, input bit abort);
        bit busy_pre, ready, accept, drop;
        n++;
        busy_pre = m_low || (n <= m_idle_at);
        ready    = !busy_pre || (PEND && !m_pend);
        accept   = trig && ready && !abort;
        drop     = trig && !ready && !abort;
        m_done   = 1'b0;
        if (drop && (m_drop < 255)) m_drop++;
        if (m_low) begin
            if (accept) m_pend = 1'b1;
            if (abort) m_pend = 1'b0;
            if (abort || (n == m_end_at)) begin
                m_low     = 1'b0;
                m_done    = 1'b1;
                m_idle_at = n + GAP;
            end
        end else if (n <= m_idle_at) begin
            if (n == m_idle_at) begin
                if ((m_pend && !abort) || accept) model_start();
                m_pend = 1'b0;
            end else if (abort) begin
                m_pend = 1'b0;
            end else if (accept) begin
                m_pend = 1'b1;
            end
        end else begin
            if (accept) model_start();
            if (abort) m_pend = 1'b0;
        end
    endtask

    task automatic step(input bit trig, input bit abort);
        bit exp_busy;
        @(negedge clk_in);
        trig_in  = trig;
        abort_in = abort;
        @(posedge clk_in);
        model_edge(trig, abort);
        #1;
        exp_busy = m_low || (n < m_idle_at);
        check("key_out",    32'(key_out),    32'(!m_low));
        check("done",       32'(done),       32'(m_done));
        check("busy",       32'(busy),       32'(exp_busy));
        check("trig_ready", 32'(trig_ready), 32'(!exp_busy || (PEND && !m_pend)));
        check("drop_cnt",   32'(drop_cnt),   32'(m_drop));
    endtask

    // Reset is applied between clock edges so its effect must be visible without a clock.
    task automatic do_reset();
        @(negedge clk_in);
        #2;
        rst_n    = 1'b0;
        trig_in  = 1'b0;
        abort_in = 1'b0;
        #1;
        check("rst_key_out",    32'(key_out),    32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_trig_ready", 32'(trig_ready), 32'd1);
        check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single pulse.
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);

        // Second request two cycles into the pulse.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);

        // Abort mid-pulse, with a request hammering through the gap.
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);

        // Trigger together with abort while idle.
        step(1'b1, 1'b1);
        check("trig_abort_idle_key", 32'(key_out), 32'd1);
        check("trig_abort_idle_busy", 32'(busy), 32'd0);
        repeat (3) step(1'b0, 1'b0);

        // Abort on the last low cycle and on the last gap cycle.
        step(1'b1, 1'b0);
        repeat (HOLD - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        repeat (GAP - 1) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b0);

        // Reset in the middle of a low pulse.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        check("mid_assert_low", 32'(key_out), 32'd0);
        do_reset();
        repeat (3) step(1'b0, 1'b0);

        // Drop counter saturation.
        repeat (400) step(1'b1, 1'b0);
        check("drop_saturated", 32'(drop_cnt), 32'd255);
        repeat (30) step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        do_reset();

        // Random traffic with one reset partway through.
        for (int i = 0; i < 2500; i++) begin
            if (i == 1300) do_reset();
            step($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
